// File: rtl/arq_ctrl.sv
// Stop-and-wait ARQ scheduler: sequences each frame through send, ACK wait,
// replay and flush, and drives mapper hold, replay select and FIFO flush.
module arq_ctrl #(
    parameter int FRAME_LEN   = 64,
    parameter int TIMEOUT_CYC = 100000,
    parameter int MAX_RETRY   = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_arq_en,
    input  logic        i_frame_start,
    input  logic        i_byte_sent,
    input  logic        i_ack_valid,
    input  logic        i_ack_good,
    output logic        o_map_hold,
    output logic        o_replay,
    output logic        o_fifo_flush,
    output logic        o_send_complete,
    output logic        o_fail,
    output logic [3:0]  o_retry_cnt,
    output logic [15:0] o_good_cnt,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_REPLAY = 3'd3,
        ST_FLUSH  = 3'd4
    } state_t;

    localparam logic [11:0] LAST_BYTE = 12'(FRAME_LEN - 1);
    localparam logic [23:0] LAST_TICK = 24'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [11:0] byte_cnt_q, byte_cnt_d;
    logic [23:0] timer_q, timer_d;
    logic        arq_mode_q, arq_mode_d;
    logic [3:0]  retry_cnt_q, retry_cnt_d;
    logic [15:0] good_cnt_q, good_cnt_d;
    logic        send_complete_q, send_complete_d;
    logic        fail_q, fail_d;
    logic        map_hold_q, map_hold_d;
    logic        replay_q, replay_d;
    logic        fifo_flush_q, fifo_flush_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= ST_IDLE;
            byte_cnt_q      <= '0;
            timer_q         <= '0;
            arq_mode_q      <= 1'b0;
            retry_cnt_q     <= '0;
            good_cnt_q      <= '0;
            send_complete_q <= 1'b0;
            fail_q          <= 1'b0;
            map_hold_q      <= 1'b0;
            replay_q        <= 1'b0;
            fifo_flush_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            byte_cnt_q      <= byte_cnt_d;
            timer_q         <= timer_d;
            arq_mode_q      <= arq_mode_d;
            retry_cnt_q     <= retry_cnt_d;
            good_cnt_q      <= good_cnt_d;
            send_complete_q <= send_complete_d;
            fail_q          <= fail_d;
            map_hold_q      <= map_hold_d;
            replay_q        <= replay_d;
            fifo_flush_q    <= fifo_flush_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        byte_cnt_d      = byte_cnt_q;
        timer_d         = timer_q;
        arq_mode_d      = arq_mode_q;
        retry_cnt_d     = retry_cnt_q;
        good_cnt_d      = good_cnt_q;
        send_complete_d = 1'b0;
        fail_d          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_frame_start) begin
                    arq_mode_d = i_arq_en;
                    byte_cnt_d = '0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_byte_sent) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        timer_d = '0;
                        state_d = arq_mode_q ? ST_WAIT : ST_FLUSH;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 12'd1;
                    end
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + 24'd1;
                // A received ACK/NAK takes priority over a coincident timeout.
                if (i_ack_valid && i_ack_good) begin
                    send_complete_d = 1'b1;
                    good_cnt_d      = good_cnt_q + 16'd1;
                    state_d         = ST_FLUSH;
                end else if (i_ack_valid || (timer_q == LAST_TICK)) begin
                    if (retry_cnt_q == RETRY_MAX) begin
                        fail_d  = 1'b1;
                        state_d = ST_FLUSH;
                    end else begin
                        retry_cnt_d = retry_cnt_q + 4'd1;
                        byte_cnt_d  = '0;
                        state_d     = ST_REPLAY;
                    end
                end
            end
            ST_REPLAY: begin
                if (i_byte_sent) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        timer_d = '0;
                        state_d = ST_WAIT;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 12'd1;
                    end
                end
            end
            ST_FLUSH: begin
                retry_cnt_d = '0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Phase-decoded outputs are taken from the next state so they leave a flop.
    always_comb begin
        map_hold_d   = (state_d != ST_IDLE);
        replay_d     = (state_d == ST_REPLAY);
        fifo_flush_d = (state_d == ST_FLUSH);
    end

    assign o_map_hold      = map_hold_q;
    assign o_replay        = replay_q;
    assign o_fifo_flush    = fifo_flush_q;
    assign o_send_complete = send_complete_q;
    assign o_fail          = fail_q;
    assign o_retry_cnt     = retry_cnt_q;
    assign o_good_cnt      = good_cnt_q;
    assign o_state         = state_q;

endmodule

// File: tb/tb_arq_ctrl.sv
// Directed bench for arq_ctrl: ACK, NAK/replay, timeout exhaustion, ARQ off,
// ACK/timeout race, async reset and good counter wrap.
module tb_arq_ctrl;

    localparam int FL = 64;
    localparam int TO = 50;
    localparam int MR = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arq_en;
    logic        frame_start;
    logic        byte_sent;
    logic        ack_valid;
    logic        ack_good;
    logic        map_hold;
    logic        replay;
    logic        fifo_flush;
    logic        send_complete;
    logic        fail;
    logic [3:0]  retry_cnt;
    logic [15:0] good_cnt;
    logic [2:0]  state;

    int n_chk  = 0;
    int n_pass = 0;
    int n_cmp  = 0;
    int n_fls  = 0;
    int n_fl   = 0;
    int n_rep  = 0;

    arq_ctrl #(.FRAME_LEN(FL), .TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_arq_en        (arq_en),
        .i_frame_start   (frame_start),
        .i_byte_sent     (byte_sent),
        .i_ack_valid     (ack_valid),
        .i_ack_good      (ack_good),
        .o_map_hold      (map_hold),
        .o_replay        (replay),
        .o_fifo_flush    (fifo_flush),
        .o_send_complete (send_complete),
        .o_fail          (fail),
        .o_retry_cnt     (retry_cnt),
        .o_good_cnt      (good_cnt),
        .o_state         (state)
    );

    always #5 clk = ~clk;

    // Pulse/level counters sampled mid-cycle.
    always @(negedge clk) begin
        if (send_complete) n_cmp <= n_cmp + 1;
        if (fifo_flush)    n_fls <= n_fls + 1;
        if (fail)          n_fl  <= n_fl + 1;
        if (replay)        n_rep <= n_rep + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            byte_sent = 1'b1;
            tick();
        end
        byte_sent = 1'b0;
    endtask

    task automatic start_frame(input logic en);
        arq_en      = en;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_ack(input logic good);
        ack_valid = 1'b1;
        ack_good  = good;
        tick();
        ack_valid = 1'b0;
        ack_good  = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, output int cyc);
        cyc = 0;
        while (state !== s && cyc < lim) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int s_cmp, s_fls, s_fl, s_rep;

        rst_n = 1'b0; arq_en = 1'b0; frame_start = 1'b0; byte_sent = 1'b0;
        ack_valid = 1'b0; ack_good = 1'b0;
        repeat (3) tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_hold", 32'(map_hold), 32'd0);
        chk("rst_flush", 32'(fifo_flush), 32'd0);
        chk("rst_good", 32'(good_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Frame with ACK ten cycles after the last byte; stray bytes in WAIT_ACK.
        s_cmp = n_cmp; s_fls = n_fls;
        start_frame(1'b1);
        chk("s1_send", 32'(state), 32'd1);
        chk("s1_hold", 32'(map_hold), 32'd1);
        send_bytes(FL - 1);
        chk("s1_still_send", 32'(state), 32'd1);
        send_bytes(1);
        chk("s1_wait", 32'(state), 32'd2);
        send_bytes(5);
        repeat (5) tick();
        chk("s1_wait_hold", 32'(state), 32'd2);
        send_ack(1'b1);
        chk("s1_flush_state", 32'(state), 32'd4);
        chk("s1_flush", 32'(fifo_flush), 32'd1);
        chk("s1_complete", 32'(send_complete), 32'd1);
        chk("s1_good", 32'(good_cnt), 32'd1);
        tick();
        chk("s1_idle", 32'(state), 32'd0);
        chk("s1_hold0", 32'(map_hold), 32'd0);
        chk("s1_retry", 32'(retry_cnt), 32'd0);
        chk("s1_ncmp", 32'(n_cmp - s_cmp), 32'd1);
        chk("s1_nfls", 32'(n_fls - s_fls), 32'd1);

        // NAK, one replay pass, then ACK.
        s_rep = n_rep;
        start_frame(1'b1);
        send_bytes(FL);
        repeat (3) tick();
        send_ack(1'b0);
        chk("s2_replay_state", 32'(state), 32'd3);
        chk("s2_replay", 32'(replay), 32'd1);
        chk("s2_retry1", 32'(retry_cnt), 32'd1);
        send_bytes(FL);
        chk("s2_wait", 32'(state), 32'd2);
        chk("s2_replay0", 32'(replay), 32'd0);
        chk("s2_nrep", 32'(n_rep - s_rep), 32'(FL));
        send_ack(1'b1);
        chk("s2_flush_retry", 32'(retry_cnt), 32'd1);
        tick();
        chk("s2_retry0", 32'(retry_cnt), 32'd0);
        chk("s2_good", 32'(good_cnt), 32'd2);

        // No ACK ever: three timed-out replays, fail on the fourth timeout.
        s_fl = n_fl; s_fls = n_fls;
        start_frame(1'b1);
        send_bytes(FL);
        for (int r = 1; r <= MR; r++) begin
            wait_state(3'd3, 200, c);
            chk($sformatf("s3_to%0d", r), 32'(c), 32'(TO));
            chk($sformatf("s3_retry%0d", r), 32'(retry_cnt), 32'(r));
            if (r == 1) begin
                ack_valid = 1'b1; ack_good = 1'b1; frame_start = 1'b1;
                tick();
                ack_valid = 1'b0; ack_good = 1'b0; frame_start = 1'b0;
                chk("s3_stray_state", 32'(state), 32'd3);
                chk("s3_stray_good", 32'(good_cnt), 32'd2);
            end
            send_bytes(FL);
            chk($sformatf("s3_wait%0d", r), 32'(state), 32'd2);
        end
        wait_state(3'd4, 200, c);
        chk("s3_to4", 32'(c), 32'(TO));
        chk("s3_fail", 32'(fail), 32'd1);
        chk("s3_flush", 32'(fifo_flush), 32'd1);
        tick();
        chk("s3_idle", 32'(state), 32'd0);
        chk("s3_retry0", 32'(retry_cnt), 32'd0);
        chk("s3_good", 32'(good_cnt), 32'd2);
        chk("s3_nfail", 32'(n_fl - s_fl), 32'd1);
        chk("s3_nfls", 32'(n_fls - s_fls), 32'd1);

        // ARQ off, enable toggled mid-frame: straight to FLUSH.
        s_cmp = n_cmp;
        start_frame(1'b0);
        send_bytes(30);
        arq_en = 1'b1;
        send_bytes(FL - 30);
        chk("s4_flush", 32'(state), 32'd4);
        chk("s4_flush_pulse", 32'(fifo_flush), 32'd1);
        tick();
        chk("s4_idle", 32'(state), 32'd0);
        chk("s4_ncmp", 32'(n_cmp - s_cmp), 32'd0);

        // Good ACK coincident with the last timer cycle.
        s_rep = n_rep;
        start_frame(1'b1);
        send_bytes(FL);
        repeat (TO - 1) tick();
        chk("s5_pre", 32'(state), 32'd2);
        send_ack(1'b1);
        chk("s5_flush", 32'(state), 32'd4);
        chk("s5_complete", 32'(send_complete), 32'd1);
        chk("s5_retry", 32'(retry_cnt), 32'd0);
        tick();
        chk("s5_nrep", 32'(n_rep - s_rep), 32'd0);
        chk("s5_good", 32'(good_cnt), 32'd3);

        // Asynchronous reset in REPLAY.
        start_frame(1'b1);
        send_bytes(FL);
        send_ack(1'b0);
        send_bytes(10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_state", 32'(state), 32'd0);
        chk("s6_replay", 32'(replay), 32'd0);
        chk("s6_hold", 32'(map_hold), 32'd0);
        chk("s6_retry", 32'(retry_cnt), 32'd0);
        chk("s6_flush", 32'(fifo_flush), 32'd0);
        chk("s6_good", 32'(good_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Good counter wrap from 0xFFFF.
        force dut.good_cnt_q = 16'hFFFF;
        tick();
        release dut.good_cnt_q;
        tick();
        chk("s7_preload", 32'(good_cnt), 32'hFFFF);
        start_frame(1'b1);
        send_bytes(FL);
        send_ack(1'b1);
        chk("s7_wrap", 32'(good_cnt), 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/arq_ctrl.md
# arq_ctrl

Stop-and-wait ARQ scheduler for the sender path. It sequences each mapped frame through send, wait-for-ACK, replay and flush phases. It holds the mapper off between frames, selects the line FIFO as the transmit source during retransmission, and clears the line FIFO once a frame is resolved. It sits alongside the mapper, line FIFO and serializer in the sender and replaces the ad-hoc ARQ sequencing currently spread across them.

## Interface
Parameters:
- FRAME_LEN, 64: bytes per frame, including the FAS bytes; legal range 2..4095.
- TIMEOUT_CYC, 100000: i_clk cycles to wait for an ACK; legal range 2..2^24-1.
- MAX_RETRY, 3: retransmissions allowed before the frame is declared failed; legal range 0..15.

Ports (clock and reset): single clock i_clk; reset i_rst_n is asynchronous and active-low.
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_arq_en  in  1  ARQ enable switch; sampled on frame start.
- i_frame_start  in  1  1-cycle pulse: mapper has issued the first FAS byte of a new frame.
- i_byte_sent  in  1  1-cycle pulse per byte accepted by the serializer.
- i_ack_valid  in  1  1-cycle pulse: an ACK/NAK has been decoded from the return line.
- i_ack_good  in  1  qualifies i_ack_valid; 1 = ACK, 0 = NAK.
- o_map_hold  out  1  blocks the mapper from starting a new frame.
- o_replay  out  1  selects the line FIFO as the serializer source.
- o_fifo_flush  out  1  1-cycle pulse that resets the line FIFO.
- o_send_complete  out  1  1-cycle pulse: frame acknowledged.
- o_fail  out  1  1-cycle pulse: retries exhausted, frame dropped.
- o_retry_cnt  out  4  retransmissions of the current frame.
- o_good_cnt  out  16  acknowledged frames; wraps from 0xFFFF to 0.
- o_state  out  3  IDLE=0, SEND=1, WAIT_ACK=2, REPLAY=3, FLUSH=4.

## Operation
- Internal counters: byte_cnt is 12 bits. timer is 24 bits. arq_mode is a 1-bit latch of i_arq_en.
- IDLE:
  - On i_frame_start: latch arq_mode=i_arq_en, clear byte_cnt, go to SEND.
- SEND: count i_byte_sent.
  - On the FRAME_LEN-th pulse: if arq_mode=1, go to WAIT_ACK with timer=0; otherwise go to FLUSH.
- WAIT_ACK: timer increments every cycle.
  - On i_ack_valid with i_ack_good=1: go to FLUSH, pulse o_send_complete, increment o_good_cnt.
  - On i_ack_valid with i_ack_good=0, or when timer reaches TIMEOUT_CYC-1: if o_retry_cnt==MAX_RETRY, pulse o_fail and go to FLUSH; otherwise increment o_retry_cnt, clear byte_cnt and go to REPLAY.
- REPLAY: o_replay=1; count i_byte_sent.
  - On the FRAME_LEN-th pulse: go to WAIT_ACK with timer=0.
- FLUSH: lasts exactly 1 cycle. o_fifo_flush=1, o_retry_cnt cleared to 0 on exit, then go to IDLE.
- o_map_hold = (state != IDLE).
- o_replay is 1 only in REPLAY.
- Ignored events:
  - i_frame_start outside IDLE.
  - i_ack_valid outside WAIT_ACK.
  - i_byte_sent in IDLE, WAIT_ACK and FLUSH.
- A change of i_arq_en mid-frame has no effect until the next frame start.
- Simultaneous events: an ACK/NAK in the same cycle as timeout is handled as the ACK/NAK, and a good ACK wins. A pulse of i_byte_sent in the same cycle as a state exit is not counted toward the next phase.

## Timing
- All outputs are registered (Moore) and update on the edge after the causing input.
- Reset values: all outputs are 0, o_state=IDLE, and all internal counters are 0.
- Asserting i_rst_n low mid-operation returns the block to IDLE immediately. No flush pulse is emitted; the line FIFO has its own reset.
- Latency from i_frame_start at cycle n: o_map_hold=1 and o_state=SEND at n+1.
- Latency from the last i_byte_sent at cycle m: WAIT_ACK at m+1 (arq_mode=1), or FLUSH at m+1 (arq_mode=0).
- Good ACK at cycle k:
  - o_fifo_flush, o_send_complete and o_good_cnt+1 are visible at k+1.
  - o_state=IDLE and o_map_hold=0 at k+2.
- Timeout: if WAIT_ACK is entered at cycle t with no ACK, REPLAY (or FLUSH) occurs at t+TIMEOUT_CYC.
- Best-case frame turnaround, from end of SEND to next frame accepted: 3 cycles plus ACK latency.

## Test plan
- arq_en=1, FRAME_LEN=64, 64 byte pulses, then good ACK 10 cycles later. Expect: o_send_complete 1 pulse, o_fifo_flush 1 pulse, o_good_cnt=1, o_retry_cnt=0, IDLE at ACK+2.
- NAK after SEND, 64 replay bytes, then good ACK. Expect: o_replay high for exactly the 64 replay bytes, o_retry_cnt=1 during the replay, then 0 after FLUSH.
- No ACK ever, MAX_RETRY=3, TIMEOUT_CYC=50. Expect: 3 REPLAY phases each 50 cycles apart, o_fail pulse on the 4th timeout, flush pulse, o_good_cnt unchanged.
- arq_en=0 with 64 bytes. Expect: no WAIT_ACK, FLUSH immediately after byte 64, no o_send_complete. Toggle i_arq_en mid-SEND: the behaviour of the current frame is unchanged.
- Good ACK in the same cycle as timer=TIMEOUT_CYC-1. Expect: ACK path taken, no replay. Stray ACK and frame_start pulses in REPLAY: ignored.
- Assert i_rst_n low in REPLAY. Expect: all outputs 0 asynchronously. Preload o_good_cnt at 0xFFFF, then one good ACK: expect o_good_cnt wraps to 0.
